// File: rtl/decode_stage_pkg.sv
// Shared MIPS32 decode definitions: opcode/funct values, ALU and branch encodings,
// immediate formats and the ID/EX register layout.
package decode_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_LUI = 4'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10
    } branch_e;

    typedef enum logic [1:0] {
        IMM_SIGN  = 2'd0,
        IMM_ZERO  = 2'd1,
        IMM_UPPER = 2'd2,
        IMM_JUMP  = 2'd3
    } imm_sel_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    mem_to_reg;
        logic    jump;
        branch_e branch;
        logic    illegal;
    } ctrl_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [4:0]  shamt;
        ctrl_t       ctrl;
    } idex_t;

endpackage

// File: rtl/decode_stage_control_decoder.sv
// Combinational opcode/funct decoder producing control flags, immediate format
// and which source registers the instruction actually reads.
module control_decoder
    import decode_stage_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl,
    output imm_sel_e   imm_sel,
    output logic       reg_dst_rd,
    output logic       uses_rs,
    output logic       uses_rt
);

    always_comb begin
        ctrl       = '0;
        imm_sel    = IMM_SIGN;
        reg_dst_rd = 1'b0;
        uses_rs    = 1'b1;
        uses_rt    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reg_dst_rd     = 1'b1;
                uses_rt        = 1'b1;
                ctrl.reg_write = 1'b1;
                case (funct)
                    FN_ADD: ctrl.alu_op = ALU_ADD;
                    FN_SUB: ctrl.alu_op = ALU_SUB;
                    FN_AND: ctrl.alu_op = ALU_AND;
                    FN_OR:  ctrl.alu_op = ALU_OR;
                    FN_SLT: ctrl.alu_op = ALU_SLT;
                    FN_SLL: begin ctrl.alu_op = ALU_SLL; uses_rs = 1'b0; end
                    FN_SRL: begin ctrl.alu_op = ALU_SRL; uses_rs = 1'b0; end
                    default: begin
                        // Unknown funct: no side effects and no hazard interlock.
                        ctrl.illegal   = 1'b1;
                        ctrl.reg_write = 1'b0;
                        uses_rs        = 1'b0;
                        uses_rt        = 1'b0;
                    end
                endcase
            end
            OP_ADDI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
            OP_ANDI: begin
                ctrl.alu_op = ALU_AND; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
                imm_sel = IMM_ZERO;
            end
            OP_ORI: begin
                ctrl.alu_op = ALU_OR; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
                imm_sel = IMM_ZERO;
            end
            OP_LUI: begin
                ctrl.alu_op = ALU_LUI; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
                imm_sel = IMM_UPPER; uses_rs = 1'b0;
            end
            OP_LW: begin
                ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1;
                ctrl.reg_write = 1'b1; ctrl.mem_to_reg = 1'b1;
            end
            OP_SW:  begin ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; uses_rt = 1'b1; end
            OP_BEQ: begin ctrl.alu_op = ALU_SUB; ctrl.branch = BR_BEQ; uses_rt = 1'b1; end
            OP_BNE: begin ctrl.alu_op = ALU_SUB; ctrl.branch = BR_BNE; uses_rt = 1'b1; end
            OP_J:   begin ctrl.jump = 1'b1; imm_sel = IMM_JUMP; uses_rs = 1'b0; end
            default: begin
                ctrl.illegal = 1'b1;
                uses_rs      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: register-file addressing, immediate extension,
// load-use stall detection, flush handling and the ID/EX pipeline register.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc4,
    input  logic        if_valid,
    input  logic        flush,
    output logic [4:0]  rf_read_reg1,
    output logic [4:0]  rf_read_reg2,
    input  logic [31:0] rf_out_reg1,
    input  logic [31:0] rf_out_reg2,
    output logic        stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc4,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dst,
    output logic [4:0]  ex_shamt,
    output logic [3:0]  ex_alu_op,
    output logic        ex_alu_src,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_reg_write,
    output logic        ex_mem_to_reg,
    output logic        ex_jump,
    output logic        ex_illegal,
    output logic [1:0]  ex_branch
);

    function automatic logic [31:0] extend_imm(input imm_sel_e sel, input logic [25:0] field);
        logic signed [15:0] imm_s;
        imm_s = field[15:0];
        case (sel)
            IMM_SIGN:  extend_imm = 32'(imm_s);
            IMM_ZERO:  extend_imm = {16'h0, field[15:0]};
            IMM_UPPER: extend_imm = {field[15:0], 16'h0};
            default:   extend_imm = {6'b0, field};
        endcase
    endfunction

    logic [4:0] rs, rt, rd;
    ctrl_t      ctrl;
    imm_sel_e   imm_sel;
    logic       reg_dst_rd, uses_rs, uses_rt;
    logic       load_use, bubble;
    idex_t      idex_d, idex_q;

    assign rs = if_instr[25:21];
    assign rt = if_instr[20:16];
    assign rd = if_instr[15:11];
    assign rf_read_reg1 = rs;
    assign rf_read_reg2 = rt;

    control_decoder u_dec (
        .opcode     (if_instr[31:26]),
        .funct      (if_instr[5:0]),
        .ctrl       (ctrl),
        .imm_sel    (imm_sel),
        .reg_dst_rd (reg_dst_rd),
        .uses_rs    (uses_rs),
        .uses_rt    (uses_rt)
    );

    // A load in EX whose target is read here cannot be forwarded in time.
    assign load_use = if_valid & idex_q.valid & idex_q.ctrl.mem_read & (idex_q.rt != 5'd0) &
                      (((idex_q.rt == rs) & uses_rs) | ((idex_q.rt == rt) & uses_rt));
    assign stall  = load_use & ~flush;
    assign bubble = flush | load_use | ~if_valid;

    always_comb begin
        idex_d = '0;
        if (!bubble) begin
            idex_d.valid   = 1'b1;
            idex_d.pc4     = if_pc4;
            idex_d.rs_data = (rs == 5'd0) ? 32'h0 : rf_out_reg1;
            idex_d.rt_data = (rt == 5'd0) ? 32'h0 : rf_out_reg2;
            idex_d.imm     = extend_imm(imm_sel, if_instr[25:0]);
            idex_d.rs      = rs;
            idex_d.rt      = rt;
            idex_d.dst     = reg_dst_rd ? rd : rt;
            idex_d.shamt   = if_instr[10:6];
            idex_d.ctrl    = ctrl;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) idex_q <= '0;
        else     idex_q <= idex_d;
    end

    assign ex_valid      = idex_q.valid;
    assign ex_pc4        = idex_q.pc4;
    assign ex_rs_data    = idex_q.rs_data;
    assign ex_rt_data    = idex_q.rt_data;
    assign ex_imm        = idex_q.imm;
    assign ex_rs         = idex_q.rs;
    assign ex_rt         = idex_q.rt;
    assign ex_dst        = idex_q.dst;
    assign ex_shamt      = idex_q.shamt;
    assign ex_alu_op     = idex_q.ctrl.alu_op;
    assign ex_alu_src    = idex_q.ctrl.alu_src;
    assign ex_mem_read   = idex_q.ctrl.mem_read;
    assign ex_mem_write  = idex_q.ctrl.mem_write;
    assign ex_reg_write  = idex_q.ctrl.reg_write;
    assign ex_mem_to_reg = idex_q.ctrl.mem_to_reg;
    assign ex_jump       = idex_q.ctrl.jump;
    assign ex_illegal    = idex_q.ctrl.illegal;
    assign ex_branch     = idex_q.ctrl.branch;

endmodule
